cache_port_responder: RTL

//  Responder end of the CPU cache port (read/write/address/wdata/mbe -> resp/rdata). Stands in for
//  an I- or D-cache: word-wide byte-enabled scratchpad that answers each request after a fixed

---
 rtl/cache_port_responder_pkg.sv | 17 +
 rtl/cache_port_responder_bemem_array.sv | 29 ++
 rtl/cache_port_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cache_port_responder_pkg.sv
// Shared types for the cache-port responder: FSM states, operation kinds and counter width.
package cache_port_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/cache_port_responder_bemem_array.sv
// Word-wide scratchpad with per-byte write enables and a combinational read port; contents never reset.
module bemem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [2**ADDR_BITS];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cache_port_responder.sv
// Fixed-latency cache-port responder backed by a byte-enabled scratchpad.
// Optional protocol checker: define CACHE_PORT_RESPONDER_PROTOCOL_CHECK_EN.
module cache_port_responder
  import cache_port_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [3:0]  mbe,
  output logic        resp,
  output logic [31:0] rdata,
  output logic        proto_err
);

  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

  state_t                r_state;
  op_t                   r_op;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_mbe;
  logic [LAT_W-1:0]      r_cnt;
  logic                  r_resp;
  logic [31:0]           r_rdata;

  logic                  w_req;
  op_t                   w_op;
  logic [ADDR_BITS-1:0]  w_rd_idx;
  logic                  w_mem_we;
  logic [31:0]           w_mem_rdata;

  // Request decode; write wins when both strobes are high
  always_comb begin
    w_req    = read | write;
    w_op     = OP_READ;
    w_rd_idx = r_idx;
    if (write) begin
      w_op = OP_WRITE;
    end else begin
      w_op = OP_READ;
    end
    // With LATENCY==1 the array is read on the IDLE edge, before the index is latched
    if (r_state == IDLE) begin
      w_rd_idx = address[ADDR_BITS+1:2];
    end else begin
      w_rd_idx = r_idx;
    end
    w_mem_we = (r_state == RESP) && (r_op == OP_WRITE);
  end

  bemem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (r_mbe),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  // Request FSM with registered resp and rdata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_op    <= OP_READ;
      r_idx   <= '0;
      r_wdata <= 32'h0000_0000;
      r_mbe   <= 4'h0;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          if (w_req) begin
            r_op    <= w_op;
            r_idx   <= address[ADDR_BITS+1:2];
            r_wdata <= wdata;
            r_mbe   <= mbe;
            r_cnt   <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
              if (w_op == OP_READ) begin
                r_rdata <= w_mem_rdata;
              end else begin
                r_rdata <= r_rdata;
              end
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
            if (r_op == OP_READ) begin
              r_rdata <= w_mem_rdata;
            end else begin
              r_rdata <= r_rdata;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign resp  = r_resp;
  assign rdata = r_rdata;

`ifdef CACHE_PORT_RESPONDER_PROTOCOL_CHECK_EN
  logic        r_lat_read;
  logic        r_lat_write;
  logic [31:0] r_lat_addr;
  logic        r_proto_err;
  logic        w_viol;

  // Any strobe or payload change while a request is outstanding is a violation
  always_comb begin
    w_viol = read & write;
    if (r_state != IDLE) begin
      w_viol = w_viol | (read != r_lat_read) | (write != r_lat_write) |
               (address != r_lat_addr) | (wdata != r_wdata) | (mbe != r_mbe);
    end else begin
      w_viol = read & write;
    end
  end

  // Raw request capture and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_read  <= 1'b0;
      r_lat_write <= 1'b0;
      r_lat_addr  <= 32'h0000_0000;
      r_proto_err <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_lat_read  <= read;
        r_lat_write <= write;
        r_lat_addr  <= address;
      end else begin
        r_lat_addr  <= r_lat_addr;
      end
      if (w_viol) begin
        r_proto_err <= 1'b1;
      end else begin
        r_proto_err <= r_proto_err;
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  logic w_addr_unused;
  assign w_addr_unused = ^{address[31:ADDR_BITS+2], address[1:0]};
  assign proto_err     = 1'b0;
`endif

endmodule
